// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared encodings for the iterative RV32M multiply/divide unit.
//   md_op_e    - operation codes, equal to the RV32M funct3 field
//   md_state_e - control states of muldiv_unit (IDLE / CALC / DONE)
//   MD_WIDTH   - datapath width
package muldiv_unit_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MDOP_MUL    = 3'd0,
        MDOP_MULH   = 3'd1,
        MDOP_MULHSU = 3'd2,
        MDOP_MULHU  = 3'd3,
        MDOP_DIV    = 3'd4,
        MDOP_DIVU   = 3'd5,
        MDOP_REM    = 3'd6,
        MDOP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_unit_step.sv
// muldiv_unit_step: one combinational iteration of the multiply/divide loop.
//   is_div - 1: restoring-division step, 0: shift-add multiply step
//   acc_i  - high product half (multiply) / partial remainder (divide), 33 bits
//   lo_i   - low product half holding the multiplier (multiply) / dividend-quotient shifter (divide)
//   opnd_i - multiplicand magnitude (multiply) / divisor magnitude (divide)
//   acc_o, lo_o - register values after this iteration
module muldiv_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] shl_s;
    logic [WIDTH:0] diff_s;
    logic           ge_s;

    // Single iteration: add-then-shift-right for multiply, shift-left-subtract for divide
    always_comb begin
        // acc_i is always below 2^WIDTH in multiply mode, so the 33-bit add cannot overflow
        sum_s  = acc_i + (lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        shl_s  = {acc_i[WIDTH-1:0], lo_i[WIDTH-1]};
        diff_s = shl_s - {1'b0, opnd_i};
        ge_s   = (shl_s >= {1'b0, opnd_i});
        acc_o  = acc_i;
        lo_o   = lo_i;
        if (is_div) begin
            if (ge_s) begin
                acc_o = diff_s;
                lo_o  = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = shl_s;
                lo_o  = {lo_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {1'b0, sum_s[WIDTH:1]};
            lo_o  = {sum_s[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Ports:
//   clk, rstn       - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready - request handshake; in_ready is high only in IDLE
//   op, A, B        - funct3 operation code and rs1/rs2 operands, latched on accept
//   flush           - abandons the in-flight operation, blocks a same-cycle accept
//   busy            - high from accept until the result cycle has passed
//   out_valid, C    - one-cycle result pulse; C holds until the next result
// Normal operations take 32 CALC cycles plus one DONE cycle. Divide-by-zero and
// signed overflow go straight to DONE. Defining MULDIV_FAST_MUL_EN computes the
// four multiply ops with a single 33x33 signed multiplier on the direct path.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] C
);

    localparam int CW = $clog2(ITER);

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        cond_neg = n ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH:0]    acc_q, acc_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic              neg_q, neg_d;
    logic [WIDTH-1:0]  c_q, c_d;

    logic              accept_s, sa_s, sb_s, neg_s, special_s;
    logic [WIDTH-1:0]  a_mag_s, b_mag_s, special_c_s, final_s;
    logic [WIDTH:0]    acc_nxt_s;
    logic [WIDTH-1:0]  lo_nxt_s;
    logic [2*WIDTH-1:0] prod_s;
`ifdef MULDIV_FAST_MUL_EN
    logic signed [WIDTH:0]     fa_s, fb_s;
    logic signed [2*WIDTH+1:0] fp_s;
`endif

    muldiv_unit_step #(.WIDTH(WIDTH)) u_step (
        .is_div (op_q[2]),
        .acc_i  (acc_q),
        .lo_i   (lo_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_nxt_s),
        .lo_o   (lo_nxt_s)
    );

    // Accept decode: operand magnitudes, result sign and the direct-to-DONE cases
    always_comb begin
        accept_s    = in_valid && (state_q == MD_IDLE) && !flush;
        sa_s        = A[WIDTH-1] && ((op == MDOP_MULH) || (op == MDOP_MULHSU) ||
                                     (op == MDOP_DIV)  || (op == MDOP_REM));
        sb_s        = B[WIDTH-1] && ((op == MDOP_MULH) || (op == MDOP_DIV) || (op == MDOP_REM));
        a_mag_s     = cond_neg(A, sa_s);
        b_mag_s     = cond_neg(B, sb_s);
        // remainder follows the dividend; quotient and products follow sign(A)^sign(B)
        neg_s       = (op == MDOP_REM) ? sa_s : (sa_s ^ sb_s);
        special_s   = 1'b0;
        special_c_s = {WIDTH{1'b0}};
        if (op[2] && (B == {WIDTH{1'b0}})) begin
            special_s   = 1'b1;
            special_c_s = op[1] ? A : {WIDTH{1'b1}};
        end else if (((op == MDOP_DIV) || (op == MDOP_REM)) &&
                     (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == {WIDTH{1'b1}})) begin
            special_s   = 1'b1;
            special_c_s = op[1] ? {WIDTH{1'b0}} : A;
        end else begin
            special_s   = 1'b0;
        end
`ifdef MULDIV_FAST_MUL_EN
        fa_s = $signed({sa_s, A});
        fb_s = $signed({sb_s, B});
        fp_s = fa_s * fb_s;
        if (!op[2]) begin
            special_s   = 1'b1;
            special_c_s = (op == MDOP_MUL) ? fp_s[WIDTH-1:0] : fp_s[2*WIDTH-1:WIDTH];
        end else begin
            special_s   = special_s;
        end
`endif
    end

    // Final-iteration result selection with sign fix-up
    always_comb begin
        prod_s = {acc_nxt_s[WIDTH-1:0], lo_nxt_s};
        prod_s = neg_q ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
        case (op_q)
            MDOP_MUL:                          final_s = prod_s[WIDTH-1:0];
            MDOP_MULH, MDOP_MULHSU, MDOP_MULHU: final_s = prod_s[2*WIDTH-1:WIDTH];
            MDOP_DIV, MDOP_DIVU:               final_s = cond_neg(lo_nxt_s, neg_q);
            default:                           final_s = cond_neg(acc_nxt_s[WIDTH-1:0], neg_q);
        endcase
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        c_d     = c_q;
        case (state_q)
            MD_IDLE: begin
                if (accept_s) begin
                    op_d   = op;
                    neg_d  = neg_s;
                    cnt_d  = {CW{1'b0}};
                    acc_d  = {(WIDTH+1){1'b0}};
                    lo_d   = op[2] ? a_mag_s : b_mag_s;
                    opnd_d = op[2] ? b_mag_s : a_mag_s;
                    if (special_s) begin
                        state_d = MD_DONE;
                        c_d     = special_c_s;
                    end else begin
                        state_d = MD_CALC;
                    end
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_CALC: begin
                if (flush) begin
                    state_d = MD_IDLE;
                end else begin
                    acc_d = acc_nxt_s;
                    lo_d  = lo_nxt_s;
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_d = MD_DONE;
                        c_d     = final_s;
                    end else begin
                        state_d = MD_CALC;
                    end
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= MD_IDLE;
            cnt_q   <= {CW{1'b0}};
            op_q    <= 3'd0;
            acc_q   <= {(WIDTH+1){1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            opnd_q  <= {WIDTH{1'b0}};
            neg_q   <= 1'b0;
            c_q     <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            c_q     <= c_d;
        end
    end

    // flush must suppress a result already sitting in DONE, so out_valid is gated late
    assign in_ready  = (state_q == MD_IDLE);
    assign busy      = (state_q != MD_IDLE);
    assign out_valid = (state_q == MD_DONE) && !flush;
    assign C         = c_q;

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0, rstn = 1'b1, in_valid = 1'b0, flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = 32'd0, B = 32'd0;
    logic        in_ready, busy, out_valid;
    logic [31:0] C;
    int          n_vec = 0, n_err = 0;

    muldiv_unit dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .A(A), .B(B), .flush(flush), .busy(busy), .out_valid(out_valid), .C(C)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // RV32M arithmetic straight from the ISA definition
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ua, ub, up;
        logic               ovf;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            OP_MUL:    begin up = ua * ub; return up[31:0]; end
            OP_MULH:   begin sp = sa * sb; return sp[63:32]; end
            OP_MULHSU: begin sp = sa * $signed(ub); return sp[63:32]; end
            OP_MULHU:  begin up = ua * ub; return up[63:32]; end
            OP_DIV:    begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                sp = sa / sb; return sp[31:0];
            end
            OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                sp = sa % sb; return sp[31:0];
            end
            default:   return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Cycles from accept edge to the out_valid cycle
    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2]) begin
            if (b == 32'd0) return 1;
            if ((f == OP_DIV || f == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return MUL_LAT;
    endfunction

    // Transaction-level model: accept time, result-cycle index, visible C
    int          cyc = 0, m_done = 0;
    logic        m_busy = 1'b0;
    logic [31:0] m_c = 32'd0, m_pend = 32'd0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy <= 1'b0;
            m_c    <= 32'd0;
        end else begin
            cyc <= cyc + 1;
            if (m_busy) begin
                if (flush || cyc == m_done) m_busy <= 1'b0;
                else if (cyc + 1 == m_done) m_c <= m_pend;
            end else if (in_valid && !flush) begin
                m_busy <= 1'b1;
                m_done <= cyc + ref_latency(op, A, B);
                m_pend <= ref_result(op, A, B);
                if (ref_latency(op, A, B) == 1) m_c <= ref_result(op, A, B);
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        check("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("out_valid", {31'd0, out_valid}, {31'd0, (m_busy && cyc == m_done && !flush)});
        check("C", C, m_c);
    end

    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1; op = f; A = a; B = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0; A = $urandom; B = $urandom; op = 3'($urandom_range(7, 0));
    endtask

    task automatic wait_result(input string nm, input int exp_lat, input logic [31:0] exp_c);
        int   k;
        logic got;
        k = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            got = out_valid;
        end
        check({nm, " latency"}, 32'(k), 32'(exp_lat));
        check({nm, " result"}, C, exp_c);
    endtask

    task automatic run(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_c, input int exp_lat);
        check({nm, " model"}, ref_result(f, a, b), exp_c);
        start_op(f, a, b);
        wait_result(nm, exp_lat, exp_c);
    endtask

    initial begin
        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst C", C, 32'd0);
        rstn = 1'b1;

        run("mul neg", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run("mulhu max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run("mulh -1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, MUL_LAT);
        run("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);
        run("mulh min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run("mul 7x3", OP_MUL, 32'd7, 32'd3, 32'd21, MUL_LAT);
        run("div neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run("rem neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run("div negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run("rem negb", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        run("divu big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        run("remu big", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run("div by0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run("rem by0", OP_REM, 32'd5, 32'd0, 32'd5, 1);
        run("divu by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run("remu by0", OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        run("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // flush in cycle 10 of a divide, new multiply accepted at edge 11
        start_op(OP_DIV, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; op = OP_MUL; A = 32'd6; B = 32'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result("post-flush mul", MUL_LAT, 32'd42);

        // flush together with a request in IDLE: no accept
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; op = OP_DIV; A = 32'd9; B = 32'd0;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("idle flush busy", {31'd0, busy}, 32'd0);

        // flush during DONE suppresses the pulse but C already carries the result
        start_op(OP_DIVU, 32'd9, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        check("done flush out_valid", {31'd0, out_valid}, 32'd0);
        check("done flush C", C, 32'hFFFF_FFFF);
        @(posedge clk);
        #1 flush = 1'b0;

        // async reset in cycle 5 of a multiply
        run("pre-reset mul", OP_MUL, 32'd9, 32'd9, 32'd81, MUL_LAT);
        start_op(OP_MUL, 32'd9, 32'd9);
        repeat (5) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset C", C, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        run("after reset", OP_DIVU, 32'd50, 32'd5, 32'd10, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Accepts one operation per handshake and runs a radix-2 shift-add or restoring-division loop.
- Returns one result word; hazard logic stalls the pipeline while busy is high.
- Results feed the same EX result mux as the ALU output C.

Parameters:
- WIDTH, 32, operand/result width; only 32 is verified.
- ITER, WIDTH, number of CALC iterations; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; high only in IDLE
- op  in  3  MDOp code (funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
- A  in  WIDTH  rs1 operand
- B  in  WIDTH  rs2 operand
- flush  in  1  kill in-flight operation (branch redirect / exception)
- busy  out  1  operation accepted and result not yet delivered
- out_valid  out  1  one-cycle pulse, result valid
- C  out  WIDTH  result; held stable until the next accept

Behaviour:
- Reset (async, rstn=0): state=IDLE, in_ready=1, busy=0, out_valid=0, C=0, all internal registers=0. Reset mid-operation abandons the operation; no out_valid is produced.
- Accept: in_valid & in_ready on a rising edge. A, B and op are latched. Inputs are don't-care afterwards.
- States:
  - IDLE → CALC on accept.
  - IDLE → DONE on accept when a special case applies (see below).
  - CALC: iteration counter counts 0..ITER-1. CALC → DONE after the ITER-th iteration.
  - DONE: out_valid=1 and C is valid for exactly one cycle. DONE → IDLE unconditionally.
- Latency: accept at edge N. Normal ops: out_valid high during cycle N+33. Special cases: out_valid high during cycle N+1.
- busy=1 in CALC and DONE. in_ready = (state==IDLE). No accept is possible in DONE; back-to-back accept is possible in the cycle after DONE.
- Sign handling:
  - Operands are converted to magnitudes at accept:
    - MULH: both operands signed.
    - MULHSU: A signed, B unsigned.
    - DIV/REM: both operands signed.
    - Unsigned ops: no conversion.
  - The result is negated in the final CALC cycle when required.
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
- Multiply: 64-bit product register.
  - MUL returns the low 32 bits.
  - MULH/MULHSU/MULHU return the high 32 bits.
- Divide: restoring algorithm with a 33-bit partial remainder.
  - DIV/DIVU return the quotient.
  - REM/REMU return the remainder.
- Special cases (DONE directly, no CALC):
  - B==0 with DIV/DIVU: C=0xFFFFFFFF.
  - B==0 with REM/REMU: C=A.
  - A==0x80000000 and B==0xFFFFFFFF with DIV: C=0x80000000.
  - A==0x80000000 and B==0xFFFFFFFF with REM: C=0.
- Flush:
  - In CALC or DONE: next state is IDLE, out_valid is forced 0 that cycle, C is unchanged.
  - flush together with in_valid in IDLE: the request is not accepted.
  - flush in IDLE otherwise has no effect.
- Op codes outside the defined set cannot occur (3-bit encoding is full).

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: the four multiply ops compute with a single combinational 33x33 signed multiply. They take the IDLE → DONE path, so out_valid is in cycle N+1. Divides are unchanged.
- Undefined: all ops use the iterative path with the latencies stated above.

Decomposition:
- Shared defines go in ctrl_encode_def.v:
  - `MDOp_mul..`MDOp_remu (3-bit, equal to funct3).
  - `MD_IDLE/`MD_CALC/`MD_DONE state encodings.
- One natural sub-module: muldiv_step. It is a combinational single-iteration datapath (add-shift for multiply, subtract-compare-shift for divide) selected by an is_div input. The FSM, counter and sign fix-up stay in muldiv_unit.

Test Plan:
- MUL A=7, B=0xFFFFFFFD accepted at edge 0 → out_valid only in cycle 33, C=0xFFFFFFEB; in_ready low cycles 1–33.
- MULHU A=B=0xFFFFFFFF → C=0xFFFFFFFE. MULH A=B=0xFFFFFFFF → C=0. MULHSU A=0xFFFFFFFF, B=2 → C=0xFFFFFFFF.
- DIV A=0xFFFFFFF9, B=2 → C=0xFFFFFFFD. REM same operands → C=0xFFFFFFFF. DIVU A=100, B=7 → C=14. REMU same operands → C=2.
- Special cases, all with out_valid in cycle 1:
  - DIV A=5, B=0 → C=0xFFFFFFFF.
  - REM A=5, B=0 → C=5.
  - DIV 0x80000000 / 0xFFFFFFFF → C=0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → C=0.
- flush at cycle 10 of a DIV → no out_valid; in_ready=1 in cycle 11. A new MUL accepted at edge 11 completes normally in cycle 44.
- rstn low at cycle 5 of a MUL → busy=0 and out_valid=0 immediately, C=0, in_ready=1; no stray out_valid later. With MULDIV_FAST_MUL_EN defined: MUL 7×3 → C=21 in cycle 1.
